// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg : shared types and constants for the DES accelerator datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package des_pkg;

  typedef logic [63:0] des_word_t;

  localparam int DES_KV_DEPTH = 64;

  typedef enum logic {
    KV_CLEAR = 1'b0,
    KV_READY = 1'b1
  } kv_state_e;

endpackage

`default_nettype wire

// File: rtl/des_kv_ram.sv
// ---------------------------------------------------------------------------
// des_kv_ram : simple dual-port array, one write port, one registered read port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module des_kv_ram
  import des_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = DES_KV_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data holds between read enables so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/des_kv_store.sv
// ---------------------------------------------------------------------------
// des_kv_store : key/message store with clear sweep, valid tracking and count
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module des_kv_store
  import des_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = DES_KV_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_key_en_i,
  input  logic              wr_msg_en_i,
  input  logic [DATA_W-1:0] wr_key_i,
  input  logic [DATA_W-1:0] wr_msg_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_key_o,
  output logic [DATA_W-1:0] rsp_msg_o,
  output logic              rsp_hit_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  kv_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DEPTH-1:0]  kvalid_q, kvalid_d, mvalid_q, mvalid_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              byp_key_q, byp_key_d, byp_msg_q, byp_msg_d;
  logic [DATA_W-1:0] byp_kdat_q, byp_kdat_d, byp_mdat_q, byp_mdat_d;

  logic              ready, wr_fire, rd_fire, wr_inr, rd_inr, wr_do, same;
  logic              key_we, msg_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] key_wdata, msg_wdata, ram_key, ram_msg;

  assign ready      = (state_q == KV_READY);
  assign busy_o     = (state_q == KV_CLEAR);
  assign wr_ready_o = ready && !clr_i;
  assign rd_ready_o = ready && !clr_i && (!rsp_valid_q || rsp_ready_i);
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign rd_fire    = rd_valid_i && rd_ready_o;
  assign wr_inr     = ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_inr     = ({1'b0, rd_addr_i} < DEPTH_L);
  assign wr_do      = wr_fire && wr_inr;
  assign same       = wr_do && (wr_addr_i == rd_addr_i);

  // The sweep owns both write ports while clearing.
  assign key_we    = busy_o || (wr_do && wr_key_en_i);
  assign msg_we    = busy_o || (wr_do && wr_msg_en_i);
  assign ram_waddr = busy_o ? ptr_q : wr_addr_i;
  assign key_wdata = busy_o ? '0 : wr_key_i;
  assign msg_wdata = busy_o ? '0 : wr_msg_i;

  des_kv_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_key_ram (
    .clk(clk), .we_i(key_we), .waddr_i(ram_waddr), .wdata_i(key_wdata),
    .re_i(rd_fire), .raddr_i(rd_addr_i), .rdata_o(ram_key)
  );

  des_kv_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_msg_ram (
    .clk(clk), .we_i(msg_we), .waddr_i(ram_waddr), .wdata_i(msg_wdata),
    .re_i(rd_fire), .raddr_i(rd_addr_i), .rdata_o(ram_msg)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    kvalid_d = kvalid_q;
    mvalid_d = mvalid_q;
    count_d  = count_q;
    case (state_q)
      KV_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = KV_READY;
          ptr_d   = '0;
        end
      end
      KV_READY: begin
        if (clr_i) begin
          state_d  = KV_CLEAR;
          ptr_d    = '0;
          kvalid_d = '0;
          mvalid_d = '0;
          count_d  = '0;
        end else if (wr_do) begin
          if (wr_key_en_i) kvalid_d[wr_addr_i] = 1'b1;
          if (wr_msg_en_i) mvalid_d[wr_addr_i] = 1'b1;
          if (!(kvalid_q[wr_addr_i] && mvalid_q[wr_addr_i]) &&
              kvalid_d[wr_addr_i] && mvalid_d[wr_addr_i])
            count_d = count_q + 1'b1;
        end
      end
      default: state_d = KV_CLEAR;
    endcase
  end

  // Write-first is resolved per half: the RAM returns the old word and the
  // captured write data replaces it on the output when that half was written.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_zero_d  = rsp_zero_q;
    byp_key_d   = byp_key_q;
    byp_msg_d   = byp_msg_q;
    byp_kdat_d  = byp_kdat_q;
    byp_mdat_d  = byp_mdat_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_zero_d  = !rd_inr;
      byp_key_d   = same && wr_key_en_i;
      byp_msg_d   = same && wr_msg_en_i;
      byp_kdat_d  = wr_key_i;
      byp_mdat_d  = wr_msg_i;
      rsp_hit_d   = rd_inr &&
                    (kvalid_q[rd_addr_i] || (same && wr_key_en_i)) &&
                    (mvalid_q[rd_addr_i] || (same && wr_msg_en_i));
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= KV_CLEAR;
      ptr_q       <= '0;
      kvalid_q    <= '0;
      mvalid_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_zero_q  <= 1'b1;
      byp_key_q   <= 1'b0;
      byp_msg_q   <= 1'b0;
      byp_kdat_q  <= '0;
      byp_mdat_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      kvalid_q    <= kvalid_d;
      mvalid_q    <= mvalid_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_zero_q  <= rsp_zero_d;
      byp_key_q   <= byp_key_d;
      byp_msg_q   <= byp_msg_d;
      byp_kdat_q  <= byp_kdat_d;
      byp_mdat_q  <= byp_mdat_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign count_o     = count_q;
  assign rsp_key_o   = rsp_zero_q ? '0 : (byp_key_q ? byp_kdat_q : ram_key);
  assign rsp_msg_o   = rsp_zero_q ? '0 : (byp_msg_q ? byp_mdat_q : ram_msg);

endmodule

`default_nettype wire
